// File: rtl/pipe_pkg.sv
// Shared definitions for the generic elastic pipeline-stage register:
// occupancy encoding and default payload/control widths per concrete stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = 4;
    localparam int ID_EX_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_DATA_W = 64;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 48;
    localparam int MEM_WB_CTRL_W = 4;
    localparam int PERF_CNT_W    = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with a clear that overrides increment; frozen when en=0.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline register with a 2-entry skid buffer, flush,
// global freeze and saturating stall/bubble counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [CTRL_W-1:0] e0_ctrl_q, e0_ctrl_d, e1_ctrl_q, e1_ctrl_d;
    logic              push, pop;

    // Ready depends only on held state and the enable, never on out_ready;
    // the reset term keeps every output low while reset is asserted.
    assign in_ready  = clk_en && reset && (state_q != FULL);
    assign out_valid = clk_en && (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = e0_data_q;
    assign out_ctrl  = e0_ctrl_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        e0_data_d = e0_data_q;
        e0_ctrl_d = e0_ctrl_q;
        e1_data_d = e1_data_q;
        e1_ctrl_d = e1_ctrl_q;
        if (flush) begin
            state_d   = EMPTY;
            e0_data_d = '0;
            e0_ctrl_d = '0;
            e1_data_d = '0;
            e1_ctrl_d = '0;
        end else if (clk_en) begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        e0_data_d = in_data;
                        e0_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        e0_data_d = in_data;
                        e0_ctrl_d = in_ctrl;
                    end else if (push) begin
                        state_d   = FULL;
                        e1_data_d = in_data;
                        e1_ctrl_d = in_ctrl;
                    end else if (pop) begin
                        state_d   = EMPTY;
                        e0_data_d = '0;
                        e0_ctrl_d = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d   = ONE;
                        e0_data_d = e1_data_q;
                        e0_ctrl_d = e1_ctrl_q;
                        e1_data_d = '0;
                        e1_ctrl_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: the two entries are plain flops, so they are reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            e0_data_q <= '0;
            e0_ctrl_q <= '0;
            e1_data_q <= '0;
            e1_ctrl_q <= '0;
        end else begin
            state_q   <= state_d;
            e0_data_q <= e0_data_d;
            e0_ctrl_q <= e0_ctrl_d;
            e1_data_q <= e1_data_d;
            e1_ctrl_q <= e1_ctrl_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .inc   (out_valid && !out_ready),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (clk_en),
        .inc   (out_ready && !out_valid),
        .clr   (cnt_clr),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for the per-cycle
// handshake/data/counter behaviour plus hand sequences for reset and saturation.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 24;

    logic              clk;
    logic              reset;
    logic              clk_en;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              ce, fl, iv, ordy, clr, chk_cnt;
        logic [DATA_W-1:0] id;
        logic [CTRL_W-1:0] ic;
        logic              e_ir, e_ov;
        logic [DATA_W-1:0] e_data;
        logic [CTRL_W-1:0] e_ctrl;
        logic [CNT_W-1:0]  e_stall, e_bubble;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(logic ce, logic fl, logic iv, logic [DATA_W-1:0] id,
                                logic [CTRL_W-1:0] ic, logic ordy, logic clr, logic chk,
                                logic eir, logic eov, logic [DATA_W-1:0] ed,
                                logic [CTRL_W-1:0] ec, logic [CNT_W-1:0] es,
                                logic [CNT_W-1:0] eb);
        vec_t v;
        v.ce = ce; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.clr = clr; v.chk_cnt = chk; v.e_ir = eir; v.e_ov = eov; v.e_data = ed;
        v.e_ctrl = ec; v.e_stall = es; v.e_bubble = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic fl, input logic iv,
                         input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                         input logic ordy, input logic clr);
        clk_en = ce; flush = fl; in_valid = iv; in_data = id; in_ctrl = ic;
        out_ready = ordy; cnt_clr = clr;
    endtask

    initial begin
        // Cycle-by-cycle vectors: outputs are those seen before the edge that
        // consumes the row's inputs; counters reflect all earlier edges.
        //            ce fl iv id       ic        ordy clr chk  ir ov data    ctrl     st bu
        vecs[0]  = mk(1, 0, 1, 64'h1,   16'h11,   1,   1,  0,   1, 0, 64'h0,  16'h0,   0, 0);
        vecs[1]  = mk(1, 0, 1, 64'h2,   16'h22,   1,   0,  1,   1, 1, 64'h1,  16'h11,  0, 0);
        vecs[2]  = mk(1, 0, 1, 64'h3,   16'h33,   1,   0,  1,   1, 1, 64'h2,  16'h22,  0, 0);
        vecs[3]  = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 1, 64'h3,  16'h33,  0, 0);
        vecs[4]  = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 0, 64'h0,  16'h0,   0, 0);
        vecs[5]  = mk(1, 0, 1, 64'hA,   16'hA0,   0,   0,  1,   1, 0, 64'h0,  16'h0,   0, 1);
        vecs[6]  = mk(1, 0, 1, 64'hB,   16'hB0,   0,   0,  1,   1, 1, 64'hA,  16'hA0,  0, 1);
        vecs[7]  = mk(1, 0, 1, 64'hD,   16'hD0,   0,   0,  1,   0, 1, 64'hA,  16'hA0,  1, 1);
        vecs[8]  = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   0, 1, 64'hA,  16'hA0,  2, 1);
        vecs[9]  = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 1, 64'hB,  16'hB0,  2, 1);
        vecs[10] = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 0, 64'h0,  16'h0,   2, 1);
        vecs[11] = mk(1, 0, 1, 64'h21,  16'h0F,   0,   0,  1,   1, 0, 64'h0,  16'h0,   2, 2);
        vecs[12] = mk(1, 0, 1, 64'h22,  16'h0E,   0,   0,  1,   1, 1, 64'h21, 16'h0F,  2, 2);
        vecs[13] = mk(1, 1, 1, 64'hC,   16'hFFFF, 0,   0,  1,   0, 1, 64'h21, 16'h0F,  3, 2);
        vecs[14] = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 0, 64'h0,  16'h0,   4, 2);
        vecs[15] = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 0, 64'h0,  16'h0,   4, 3);
        vecs[16] = mk(1, 0, 1, 64'h55,  16'h5,    0,   0,  1,   1, 0, 64'h0,  16'h0,   4, 4);
        for (int i = 17; i <= 21; i++)
            vecs[i] = mk(0, 0, 1, 64'h66, 16'h6,  1,   0,  1,   0, 0, 64'h55, 16'h5,   4, 4);
        vecs[22] = mk(1, 0, 0, 64'h0,   16'h0,    1,   0,  1,   1, 1, 64'h55, 16'h5,   4, 4);
        vecs[23] = mk(1, 0, 0, 64'h0,   16'h0,    0,   0,  1,   1, 0, 64'h0,  16'h0,   4, 4);

        reset = 1'b0;
        drive(0, 0, 0, '0, '0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        reset = 1'b1;

        // Fill to FULL, then pull reset low between edges.
        @(negedge clk);
        drive(1, 0, 1, 64'h71, 16'h7, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 64'h72, 16'h7, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, '0, '0, 0, 0);
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_stall_cnt", stall_cnt, 1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_ctrl", out_ctrl, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_stall_cnt", stall_cnt, 0);
        check("midrst_bubble_cnt", bubble_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].ce, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic,
                  vecs[i].ordy, vecs[i].clr);
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
            check($sformatf("v%0d_out_ctrl", i), out_ctrl, vecs[i].e_ctrl);
            if (vecs[i].chk_cnt) begin
                check($sformatf("v%0d_stall_cnt", i), stall_cnt, vecs[i].e_stall);
                check($sformatf("v%0d_bubble_cnt", i), bubble_cnt, vecs[i].e_bubble);
            end
        end

        // Idle with out_ready=1: bubble counter climbs from 4 and sticks at 15.
        @(negedge clk);
        drive(1, 0, 0, '0, '0, 1, 0);
        repeat (20) @(negedge clk);
        #1;
        check("sat_bubble_cnt", bubble_cnt, 15);
        check("sat_stall_cnt", stall_cnt, 4);
        drive(1, 0, 0, '0, '0, 1, 1);
        @(negedge clk);
        #1;
        check("clr_bubble_cnt", bubble_cnt, 0);
        check("clr_stall_cnt", stall_cnt, 0);
        drive(1, 0, 0, '0, '0, 1, 0);
        @(negedge clk);
        #1;
        check("after_clr_bubble_cnt", bubble_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
